miriscv_test_seq: RTL
=====================

# miriscv_test_seq

Self-checking test sequencer for the miriscv core. It runs a campaign of NUM_VECTORS operands through the resident program. For each operand it:
- patches an `addi rd, x0, imm` instruction into instruction memory,
- pulses the core reset,
- runs the core for a fixed cycle budget,
- samples the core's result register and compares it against an expected verdict.

It sits beside `miriscv_top`, driving the RAM patch port and core reset, and replaces hand-driven bench sequencing with synthesizable control.

## Interface
- NUM_VECTORS, 4, operands per campaign (1..16)
- RST_CYCLES, 1, cycles core_rst_o held high per vector (>=1)
- RUN_CYCLES, 300, core run budget per vector (>=1)
- RD_IDX, 1, destination register of the patched addi
- PATCH_ADDR, 0, word address patched in instruction RAM

- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  campaign start; sampled only in IDLE
- vec_i  in  12*NUM_VECTORS  packed operands; vector k = vec_i[12k+11:12k]
- exp_i  in  NUM_VECTORS  expected verdict per vector (1 = result nonzero)
- result_i  in  32  core result register (x4)
- halt_i  in  1  core finished flag (used only with early exit, see Configuration)
- patch_we_o  out  1  RAM patch write enable
- patch_addr_o  out  $clog2(PATCH_ADDR+1)..32  patch word address, constant PATCH_ADDR
- patch_data_o  out  32  byte-swapped instruction word
- core_rst_o  out  1  active-high core reset
- busy_o  out  1  campaign in progress
- done_o  out  1  one-cycle campaign-complete pulse
- vec_idx_o  out  $clog2(NUM_VECTORS)  current vector index
- pass_mask_o  out  NUM_VECTORS  bit k = vector k matched
- fail_cnt_o  out  $clog2(NUM_VECTORS+1)  mismatches in last campaign

## Operation
- FSM states: IDLE, PATCH, RESET, RUN, CHECK, DONE.
- IDLE:
  - start_i=1 → PATCH.
  - On entry to PATCH: vec_idx_o, pass_mask_o and fail_cnt_o are cleared.
- PATCH (1 cycle):
  - patch_we_o=1.
  - Instruction ins = {imm, 5'b0, 3'b000, RD_IDX[4:0], 7'b0010011}.
  - patch_data_o = {ins[7:0], ins[15:8], ins[23:16], ins[31:24]}.
  - Next state: RESET.
- RESET:
  - core_rst_o=1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - core_rst_o=0.
  - Down-counter loaded with RUN_CYCLES; leave for CHECK when it reaches 0 (RUN lasts exactly RUN_CYCLES cycles).
- CHECK (1 cycle):
  - verdict = |result_i.
  - pass_mask_o[idx] = (verdict == exp_i[idx]); fail_cnt_o increments on mismatch.
  - If idx == NUM_VECTORS-1 → DONE, else idx+1 and → PATCH.
- DONE (1 cycle): done_o=1, then → IDLE.
- Result hold:
  - pass_mask_o and fail_cnt_o hold until the next start.
  - vec_idx_o holds its last value in IDLE.
- busy_o=1 in every state except IDLE.
- Ignored inputs:
  - start_i is ignored outside IDLE.
  - vec_i and exp_i are sampled at use (PATCH / CHECK) and must be stable for the whole campaign.
- core_rst_o:
  - It is 1 in IDLE, DONE, PATCH and RESET.
  - The core runs only in RUN.

## Timing
- Reset values:
  - state IDLE.
  - core_rst_o=1.
  - patch_we_o=0, patch_data_o=0.
  - busy_o=0, done_o=0.
  - vec_idx_o=0, pass_mask_o=0, fail_cnt_o=0.
- Reset mid-campaign: abandon immediately, all outputs return to reset values next edge, no done_o.
- start_i high at edge t: patch_we_o high in cycle t+1; core_rst_o falls at t+2+RST_CYCLES.
- Per-vector latency: 1 + RST_CYCLES + RUN_CYCLES + 1 cycles.
- Campaign latency: start edge to done_o = NUM_VECTORS·(RUN_CYCLES+RST_CYCLES+2) cycles. With defaults: 4·303 = 1212.
- start_i held high continuously: a new campaign starts on the cycle after DONE (back-to-back through IDLE).
- All outputs are registered; no combinational input→output path.

## Configuration
- Macro MIRISCV_TEST_SEQ_EARLY_EXIT_EN.
- Defined:
  - In RUN, halt_i=1 ends RUN at that edge → CHECK next cycle, even before the budget expires.
  - RUN_CYCLES acts as a watchdog.
  - If the budget expires with halt_i never seen, the vector is counted as fail regardless of verdict.
- Undefined:
  - halt_i is ignored.
  - RUN always lasts RUN_CYCLES cycles.
  - Verdict is compared only.

## Test plan
- Encoding: NUM_VECTORS=1, vec=61, RD_IDX=1, start pulse → single patch_we_o cycle with patch_data_o=0x9300D003, patch_addr_o=0.
- Campaign, defaults: vectors {61,60,2,1}, exp {1,0,1,0}, result_i forced to match → done_o exactly 1212 cycles after start, pass_mask_o=4'b1111, fail_cnt_o=0.
- Mismatch: same as above but result_i=0 for vector 0 → pass_mask_o=4'b1110, fail_cnt_o=1.
- Reset mid-RUN of vector 2: rst_i for one cycle → next cycle core_rst_o=1, busy_o=0, pass_mask_o=0, no done_o; start_i ignored while busy.
- Early exit with macro, RUN_CYCLES=300, halt_i at RUN cycle 10 → CHECK on cycle 11.
- No halt with macro → fail counted even though verdict matches.

Source files
------------

// File: rtl/miriscv_test_seq.sv
// Self-checking campaign sequencer for miriscv: patches an addi per operand, resets and runs the core, grades the result.
// Optional MIRISCV_TEST_SEQ_EARLY_EXIT_EN: halt_i ends RUN early and a run without halt is graded as a failure.
module miriscv_test_seq #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned RUN_CYCLES  = 300,
  parameter int unsigned RD_IDX      = 1,
  parameter int unsigned PATCH_ADDR  = 0
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  start_i,
  input  logic [12*NUM_VECTORS-1:0]                             vec_i,
  input  logic [NUM_VECTORS-1:0]                                exp_i,
  input  logic [31:0]                                           result_i,
  input  logic                                                  halt_i,
  output logic                                                  patch_we_o,
  output logic [31:0]                                           patch_addr_o,
  output logic [31:0]                                           patch_data_o,
  output logic                                                  core_rst_o,
  output logic                                                  busy_o,
  output logic                                                  done_o,
  output logic [((NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1)-1:0] vec_idx_o,
  output logic [NUM_VECTORS-1:0]                                pass_mask_o,
  output logic [$clog2(NUM_VECTORS+1)-1:0]                      fail_cnt_o
);

  localparam int unsigned IDX_W   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int unsigned FC_W    = $clog2(NUM_VECTORS + 1);
  localparam int unsigned CNT_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PATCH, S_RESET, S_RUN, S_CHECK, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_VECTORS-1:0]   mask_q, mask_d;
  logic [FC_W-1:0]          fail_q, fail_d;
  logic                     patch_we_q, patch_we_d;
  logic [31:0]              patch_data_q, patch_data_d;
  logic                     core_rst_q, core_rst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_c;
  logic [11:0]              imm_c;
  logic [31:0]              ins_c;
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
  logic                     timeout_q, timeout_d;
`else
  logic                     unused_halt;
  assign unused_halt = halt_i;
`endif

  // Next-state and campaign bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    fail_d  = fail_q;
    pass_c  = 1'b0;
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PATCH;
          idx_d   = '0;
          mask_d  = '0;
          fail_d  = '0;
        end
      end
      S_PATCH: begin
        state_d = S_RESET;
        cnt_d   = CNT_W'(RST_CYCLES - 1);
      end
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(RUN_CYCLES - 1);
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
          timeout_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
        if (halt_i) begin
          state_d = S_CHECK;
        end else if (cnt_q == '0) begin
          state_d   = S_CHECK;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`else
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      S_CHECK: begin
        pass_c = ((|result_i) == exp_i[idx_q]);
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
        pass_c = pass_c && !timeout_q;
`endif
        mask_d[idx_q] = pass_c;
        if (!pass_c) fail_d = fail_q + FC_W'(1);
        if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_PATCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register in step with it
  always_comb begin
    imm_c        = vec_i[12*idx_d +: 12];
    ins_c        = {imm_c, 5'd0, 3'b000, 5'(RD_IDX), 7'b0010011};
    patch_we_d   = (state_d == S_PATCH);
    patch_data_d = patch_we_d ? {ins_c[7:0], ins_c[15:8], ins_c[23:16], ins_c[31:24]} : 32'd0;
    core_rst_d   = (state_d != S_RUN);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      fail_q       <= '0;
      patch_we_q   <= 1'b0;
      patch_data_q <= '0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      fail_q       <= fail_d;
      patch_we_q   <= patch_we_d;
      patch_data_q <= patch_data_d;
      core_rst_q   <= core_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MIRISCV_TEST_SEQ_EARLY_EXIT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign patch_addr_o = 32'(PATCH_ADDR);
  assign patch_we_o   = patch_we_q;
  assign patch_data_o = patch_data_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign vec_idx_o    = idx_q;
  assign pass_mask_o  = mask_q;
  assign fail_cnt_o   = fail_q;

endmodule
